// File: rtl/pci_bus_arbiter_if.sv
// Bus-side signal bundle for the PCI-style central arbiter.
// The master modport is the arbiter's view; slave is the bus/initiator view.
interface pci_bus_arbiter_if #(
    parameter int NUM_REQ = 8
);
    logic [NUM_REQ-1:0] REQ;
    logic               FRAME;
    logic               IRDY;
    logic [NUM_REQ-1:0] GNT;
    logic [2:0]         OWNER;
    logic               BUSY;

    modport master (
        input  REQ,
        input  FRAME,
        input  IRDY,
        output GNT,
        output OWNER,
        output BUSY
    );

    modport slave (
        output REQ,
        output FRAME,
        output IRDY,
        input  GNT,
        input  OWNER,
        input  BUSY
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin arbiter for a shared PCI-style bus.
// Drives at most one active-low grant, supports hidden arbitration while the
// bus is busy, drops grants whose request goes away, and revokes grants that
// are not used within GNT_TIMEOUT idle bus cycles.
module pci_bus_arbiter #(
    parameter int NUM_REQ     = 8,
    parameter int GNT_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    pci_bus_arbiter_if.master bus
);
    localparam int                 TW        = $clog2(GNT_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ALL_ONES  = {NUM_REQ{1'b1}};
    localparam logic [NUM_REQ-1:0] ALL_ZEROS = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [2:0]         OWNER_RST = 3'(NUM_REQ - 1);
    localparam logic [TW-1:0]      TMO_LAST  = TW'(GNT_TIMEOUT - 1);
    localparam logic [TW-1:0]      TMO_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0]      TMO_ONE   = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } state_t;

    // Round-robin search starting just above the current owner and wrapping.
    // Result: bit 3 = a requester was found, bits 2:0 = its index.
    function automatic logic [3:0] f_rr_pick(input logic [NUM_REQ-1:0] req_n,
                                             input logic [2:0]         owner);
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(owner) + k >= NUM_REQ) ? (int'(owner) + k - NUM_REQ)
                                                : (int'(owner) + k);
            pick = (!pick[3] && !req_n[idx]) ? {1'b1, idx[2:0]} : pick;
        end
        return pick;
    endfunction

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt_n;
    logic [2:0]         r_owner;
    logic               r_busy;
    logic [TW-1:0]      r_tmo_cnt;
    logic               r_skip;
    logic               r_prev_idle;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [2:0]         w_owner_nxt;
    logic               w_busy_nxt;
    logic [TW-1:0]      w_tmo_nxt;
    logic               w_skip_nxt;

    logic               w_idle;
    logic [NUM_REQ-1:0] w_own_mask;
    logic               w_owner_req;
    logic               w_other_req;
    logic               w_gnt_out;
    logic [3:0]         w_pick_idle;
    logic [3:0]         w_pick_busy;

    assign w_idle      = bus.FRAME & bus.IRDY;
    assign w_own_mask  = ONE_HOT0 << r_owner;
    assign w_owner_req = |(~bus.REQ & w_own_mask);
    assign w_other_req = |(~bus.REQ & ~w_own_mask);
    assign w_gnt_out   = (r_gnt_n != ALL_ONES);
    // After a timeout the revoked owner sits out exactly one IDLE round.
    assign w_pick_idle = f_rr_pick(bus.REQ | (r_skip ? w_own_mask : ALL_ZEROS), r_owner);
    assign w_pick_busy = f_rr_pick(bus.REQ, r_owner);

    assign bus.GNT   = r_gnt_n;
    assign bus.OWNER = r_owner;
    assign bus.BUSY  = r_busy;

    // State register and registered outputs; reset forces the bus released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt_n     <= ALL_ONES;
            r_owner     <= OWNER_RST;
            r_busy      <= 1'b0;
            r_tmo_cnt   <= TMO_ZERO;
            r_skip      <= 1'b0;
            r_prev_idle <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_n     <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_busy      <= w_busy_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_skip      <= w_skip_nxt;
            r_prev_idle <= w_idle;
        end
    end

    // Next-state, grant, owner, busy and timeout decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_n;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_tmo_nxt   = r_tmo_cnt;
        w_skip_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_tmo_nxt  = TMO_ZERO;
                if (w_pick_idle[3]) begin
                    w_gnt_nxt   = ~(ONE_HOT0 << w_pick_idle[2:0]);
                    w_owner_nxt = w_pick_idle[2:0];
                    w_state_nxt = ST_GRANTED;
                end else begin
                    w_gnt_nxt = ALL_ONES;
                end
            end
            ST_GRANTED: begin
                w_busy_nxt = 1'b0;
                if (!bus.FRAME && r_prev_idle) begin
                    // Owner started its transaction on an idle bus.
                    w_busy_nxt  = 1'b1;
                    w_tmo_nxt   = TMO_ZERO;
                    w_state_nxt = ST_BUSY;
                end else if (!w_owner_req) begin
                    // Request withdrawn before use: one all-ones cycle, then re-arbitrate.
                    w_gnt_nxt   = ALL_ONES;
                    w_tmo_nxt   = TMO_ZERO;
                    w_state_nxt = ST_IDLE;
                end else if (w_idle) begin
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_gnt_nxt   = ALL_ONES;
                        w_tmo_nxt   = TMO_ZERO;
                        w_skip_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + TMO_ONE;
                    end
                end else begin
                    w_tmo_nxt = TMO_ZERO;
                end
            end
            ST_BUSY: begin
                if (w_idle) begin
                    w_busy_nxt  = 1'b0;
                    w_tmo_nxt   = TMO_ZERO;
                    w_state_nxt = w_gnt_out ? ST_GRANTED : ST_IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                    if (w_gnt_out) begin
                        if (w_other_req || !w_owner_req) begin
                            // Hidden hand-over (or nobody left): open the all-ones gap.
                            w_gnt_nxt = ALL_ONES;
                            w_tmo_nxt = TMO_ZERO;
                        end else begin
                            w_gnt_nxt = r_gnt_n;
                        end
                    end else if (w_pick_busy[3]) begin
                        // Gap cycle done: park the winner's grant until the bus is idle.
                        w_gnt_nxt   = ~(ONE_HOT0 << w_pick_busy[2:0]);
                        w_owner_nxt = w_pick_busy[2:0];
                        w_tmo_nxt   = TMO_ZERO;
                    end else begin
                        w_gnt_nxt = ALL_ONES;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = ALL_ONES;
                w_busy_nxt  = 1'b0;
                w_tmo_nxt   = TMO_ZERO;
            end
        endcase
    end
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed, table-driven bench for pci_bus_arbiter (NUM_REQ=8, GNT_TIMEOUT=16).
module tb_pci_bus_arbiter;
    typedef struct {
        logic [7:0] req;
        logic       frame;
        logic       irdy;
        logic [7:0] gnt;
        logic [2:0] owner;
        logic       busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pci_bus_arbiter_if #(.NUM_REQ(8)) bus_if ();

    pci_bus_arbiter #(.NUM_REQ(8), .GNT_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] g, input logic [2:0] o, input logic b);
        n_tests++;
        if (bus_if.GNT !== g || bus_if.OWNER !== o || bus_if.BUSY !== b) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h owner=%0d busy=%b, expected gnt=%h owner=%0d busy=%b",
                     name, bus_if.GNT, bus_if.OWNER, bus_if.BUSY, g, o, b);
        end
        n_tests++;
        if ($countones(~bus_if.GNT) > 1) begin
            n_fail++;
            $display("FAIL %s_onegrant: got gnt=%h, expected at most one zero bit", name, bus_if.GNT);
        end
    endtask

    // Drive inputs, let one rising edge pass, then check 1 time unit later.
    task automatic apply(input logic [7:0] req, input logic fr, input logic ir,
                         input logic [7:0] g, input logic [2:0] o, input logic b,
                         input string name);
        bus_if.REQ   = req;
        bus_if.FRAME = fr;
        bus_if.IRDY  = ir;
        @(posedge clk);
        #1;
        chk(name, g, o, b);
    endtask

    task automatic do_reset(input string name);
        rst_n        = 1'b0;
        bus_if.REQ   = 8'($urandom);
        bus_if.FRAME = 1'b1;
        bus_if.IRDY  = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_a"}, 8'hFF, 3'd7, 1'b0);
        bus_if.REQ = 8'($urandom);
        @(posedge clk);
        #1;
        chk({name, "_b"}, 8'hFF, 3'd7, 1'b0);
        bus_if.REQ = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t single_v[9];
    vec_t rr_v[17];

    initial begin
        // Single request from initiator 0 with a 4-cycle transaction.
        single_v[0] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};
        single_v[1] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};
        single_v[2] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        single_v[3] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        single_v[4] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        single_v[5] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        single_v[6] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};
        single_v[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0};
        single_v[8] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0};
        // Round-robin over initiators 0..3, each doing a 3-cycle transaction.
        rr_v[0]  = '{8'hF0, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};
        rr_v[1]  = '{8'hF0, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        rr_v[2]  = '{8'hF0, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b1};
        rr_v[3]  = '{8'hF0, 1'b0, 1'b0, 8'hFD, 3'd1, 1'b1};
        rr_v[4]  = '{8'hF0, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b0};
        rr_v[5]  = '{8'hF0, 1'b0, 1'b0, 8'hFD, 3'd1, 1'b1};
        rr_v[6]  = '{8'hF0, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b1};
        rr_v[7]  = '{8'hF0, 1'b0, 1'b0, 8'hFB, 3'd2, 1'b1};
        rr_v[8]  = '{8'hF0, 1'b1, 1'b1, 8'hFB, 3'd2, 1'b0};
        rr_v[9]  = '{8'hF0, 1'b0, 1'b0, 8'hFB, 3'd2, 1'b1};
        rr_v[10] = '{8'hF0, 1'b0, 1'b0, 8'hFF, 3'd2, 1'b1};
        rr_v[11] = '{8'hF0, 1'b0, 1'b0, 8'hF7, 3'd3, 1'b1};
        rr_v[12] = '{8'hF0, 1'b1, 1'b1, 8'hF7, 3'd3, 1'b0};
        rr_v[13] = '{8'hF0, 1'b0, 1'b0, 8'hF7, 3'd3, 1'b1};
        rr_v[14] = '{8'hF0, 1'b0, 1'b0, 8'hFF, 3'd3, 1'b1};
        rr_v[15] = '{8'hF0, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
        rr_v[16] = '{8'hF0, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};

        rst_n        = 1'b0;
        bus_if.REQ   = 8'hFF;
        bus_if.FRAME = 1'b1;
        bus_if.IRDY  = 1'b1;

        // Reset values, then nothing granted with no requests.
        do_reset("reset");
        apply(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, "idle_noreq_0");
        apply(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, "idle_noreq_1");

        for (int i = 0; i < 9; i++)
            apply(single_v[i].req, single_v[i].frame, single_v[i].irdy,
                  single_v[i].gnt, single_v[i].owner, single_v[i].busy,
                  $sformatf("single[%0d]", i));

        do_reset("reset_rr");
        for (int i = 0; i < 17; i++)
            apply(rr_v[i].req, rr_v[i].frame, rr_v[i].irdy,
                  rr_v[i].gnt, rr_v[i].owner, rr_v[i].busy,
                  $sformatf("rr[%0d]", i));

        // Hidden arbitration: 3 is busy, 5 requests; hand-over while FRAME low.
        do_reset("reset_hid");
        apply(8'hF7, 1'b1, 1'b1, 8'hF7, 3'd3, 1'b0, "hid_grant3");
        apply(8'hF7, 1'b0, 1'b0, 8'hF7, 3'd3, 1'b1, "hid_start3");
        apply(8'hDF, 1'b0, 1'b0, 8'hFF, 3'd3, 1'b1, "hid_gap");
        apply(8'hDF, 1'b0, 1'b0, 8'hDF, 3'd5, 1'b1, "hid_grant5");
        apply(8'hDF, 1'b0, 1'b0, 8'hDF, 3'd5, 1'b1, "hid_wait5");
        apply(8'hDF, 1'b1, 1'b1, 8'hDF, 3'd5, 1'b0, "hid_idle");
        apply(8'hDF, 1'b0, 1'b0, 8'hDF, 3'd5, 1'b1, "hid_start5");
        apply(8'hFF, 1'b1, 1'b1, 8'hDF, 3'd5, 1'b0, "hid_end5");
        apply(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd5, 1'b0, "hid_release");

        // Timeout: 1 granted but never starts; 2 also requests.
        do_reset("reset_tmo");
        apply(8'hF9, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b0, "tmo_grant");
        for (int i = 1; i < 16; i++)
            apply(8'hF9, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b0, $sformatf("tmo_wait[%0d]", i));
        apply(8'hF9, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0, "tmo_revoke");
        apply(8'hF9, 1'b1, 1'b1, 8'hFB, 3'd2, 1'b0, "tmo_regrant");

        // Asynchronous reset while initiator 7 is busy.
        do_reset("reset_mid");
        apply(8'h7F, 1'b1, 1'b1, 8'h7F, 3'd7, 1'b0, "mid_grant7");
        apply(8'h7F, 1'b0, 1'b0, 8'h7F, 3'd7, 1'b1, "mid_busy7");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_reset", 8'hFF, 3'd7, 1'b0);
        bus_if.REQ   = 8'hFF;
        bus_if.FRAME = 1'b1;
        bus_if.IRDY  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0, "mid_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
